// File: rtl/iir_mac_filter.sv
// iir_mac_filter: multi-channel direct-form-I IIR filter built on one time-multiplexed signed MAC.
// Define IIR_SAT_EN to clamp y and out_data; otherwise both conversions wrap.
module iir_mac_filter #(
    parameter int IO_B   = 16,
    parameter int INT_B  = 7,
    parameter int FRAC_B = 24,
    parameter int NA     = 3,
    parameter int NB     = 4,
    parameter int CH     = 2,
    localparam int Q_BITS = INT_B + FRAC_B + 1,
    localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1,
    localparam int CA_W   = $clog2(NA + NB)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [IO_B-1:0]   in_data,
    input  logic [CH_W-1:0]          in_ch,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [IO_B-1:0]   out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_valid,
    input  logic                     coef_we,
    input  logic [CA_W-1:0]          coef_addr,
    input  logic signed [Q_BITS-1:0] coef_wdata
);

    localparam int SH = FRAC_B - IO_B + 1;
    localparam int NC = NA + NB;
    localparam int PW = 2 * Q_BITS;
    localparam int AW = PW + $clog2(NC);
    localparam logic signed [Q_BITS-1:0] ONE = Q_BITS'(1) << FRAC_B;

    typedef enum logic [2:0] {IDLE, CALC_A, CALC_B, LAST_ACC, DONE, DISCARD} state_t;

    state_t                   state;
    logic [CH_W-1:0]          ch_r;
    logic [CA_W-1:0]          cntr;
    logic signed [PW-1:0]     mult;
    logic signed [PW-1:0]     prod;
    logic signed [AW-1:0]     acc;
    logic signed [Q_BITS-1:0] coef [NC];
    logic signed [Q_BITS-1:0] xh [CH][NB];
    logic signed [Q_BITS-1:0] yh [CH][NA];
    logic signed [Q_BITS-1:0] x_in;
    logic signed [Q_BITS-1:0] coef_sel;
    logic signed [Q_BITS-1:0] hist_sel;
    logic signed [Q_BITS-1:0] y_new;
    logic signed [IO_B-1:0]   out_new;
    logic                     ch_ok;
    logic                     addr_ok;

    assign x_in = Q_BITS'(in_data) <<< SH;

    if (CH == (1 << CH_W)) begin : g_ch_all
        assign ch_ok = 1'b1;
    end else begin : g_ch_cmp
        assign ch_ok = (in_ch < CH_W'(CH));
    end

    if (NC == (1 << CA_W)) begin : g_addr_all
        assign addr_ok = 1'b1;
    end else begin : g_addr_cmp
        assign addr_ok = (coef_addr < CA_W'(NC));
    end

    // Operand select for the shared multiplier: a/y during CALC_A, b/x during CALC_B.
    always_comb begin
        coef_sel = '0;
        hist_sel = '0;
        if (state == CALC_A) begin
            for (int unsigned k = 0; k < NA; k++) begin
                if (cntr == CA_W'(k)) begin
                    coef_sel = coef[k];
                    for (int unsigned c = 0; c < CH; c++)
                        if (ch_r == CH_W'(c)) hist_sel = yh[c][k];
                end
            end
        end else if (state == CALC_B) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (cntr == CA_W'(k)) begin
                    coef_sel = coef[NA + k];
                    for (int unsigned c = 0; c < CH; c++)
                        if (ch_r == CH_W'(c)) hist_sel = xh[c][k];
                end
            end
        end
        prod = PW'(coef_sel) * PW'(hist_sel);
    end

`ifdef IIR_SAT_EN
    localparam logic signed [AW-1:0]     Y_MAX = AW'({1'b0, {(Q_BITS-1){1'b1}}});
    localparam logic signed [AW-1:0]     Y_MIN = ~Y_MAX;
    localparam logic signed [Q_BITS-1:0] O_MAX = Q_BITS'({1'b0, {(IO_B-1){1'b1}}});
    localparam logic signed [Q_BITS-1:0] O_MIN = ~O_MAX;

    logic signed [AW-1:0]     acc_sh;
    logic signed [Q_BITS-1:0] y_sh;

    always_comb begin
        acc_sh = acc >>> FRAC_B;
        if (acc_sh > Y_MAX)
            y_new = {1'b0, {(Q_BITS-1){1'b1}}};
        else if (acc_sh < Y_MIN)
            y_new = {1'b1, {(Q_BITS-1){1'b0}}};
        else
            y_new = acc_sh[Q_BITS-1:0];
        y_sh = y_new >>> SH;
        if (y_sh > O_MAX)
            out_new = {1'b0, {(IO_B-1){1'b1}}};
        else if (y_sh < O_MIN)
            out_new = {1'b1, {(IO_B-1){1'b0}}};
        else
            out_new = y_sh[IO_B-1:0];
    end
`else
    logic unused_acc;

    assign y_new      = acc[FRAC_B+Q_BITS-1:FRAC_B];
    assign out_new    = y_new[SH+IO_B-1:SH];
    assign unused_acc = ^{acc[AW-1:FRAC_B+Q_BITS], acc[FRAC_B-1:0]};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ch_r      <= '0;
            cntr      <= '0;
            acc       <= '0;
            mult      <= '0;
            for (int unsigned k = 0; k < NC; k++)
                coef[k] <= (k == NA) ? ONE : '0;
            for (int unsigned c = 0; c < CH; c++) begin
                for (int unsigned k = 0; k < NB; k++) xh[c][k] <= '0;
                for (int unsigned k = 0; k < NA; k++) yh[c][k] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            // Coefficients are only read from CALC_A on, so a write on the accept edge is seen by that sample.
            if (coef_we && in_ready && addr_ok)
                for (int unsigned k = 0; k < NC; k++)
                    if (coef_addr == CA_W'(k)) coef[k] <= coef_wdata;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (ch_ok) begin
                            ch_r <= in_ch;
                            for (int unsigned c = 0; c < CH; c++) begin
                                if (in_ch == CH_W'(c)) begin
                                    for (int unsigned k = NB - 1; k > 0; k--)
                                        xh[c][k] <= xh[c][k-1];
                                    xh[c][0] <= x_in;
                                end
                            end
                            acc   <= '0;
                            mult  <= '0;
                            cntr  <= '0;
                            state <= CALC_A;
                        end else begin
                            state <= DISCARD;
                        end
                    end
                end
                CALC_A: begin
                    mult <= prod;
                    acc  <= acc + AW'(mult);
                    if (cntr == CA_W'(NA - 1)) begin
                        cntr  <= '0;
                        state <= CALC_B;
                    end else begin
                        cntr <= cntr + 1'b1;
                    end
                end
                CALC_B: begin
                    mult <= prod;
                    acc  <= acc + AW'(mult);
                    if (cntr == CA_W'(NB - 1)) begin
                        cntr  <= '0;
                        state <= LAST_ACC;
                    end else begin
                        cntr <= cntr + 1'b1;
                    end
                end
                LAST_ACC: begin
                    acc   <= acc + AW'(mult);
                    state <= DONE;
                end
                DONE: begin
                    for (int unsigned c = 0; c < CH; c++) begin
                        if (ch_r == CH_W'(c)) begin
                            for (int unsigned k = NA - 1; k > 0; k--)
                                yh[c][k] <= yh[c][k-1];
                            yh[c][0] <= y_new;
                        end
                    end
                    out_data  <= out_new;
                    out_ch    <= ch_r;
                    out_valid <= 1'b1;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                DISCARD: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_mac_filter.sv
// Self-checking bench for iir_mac_filter (default parameters): vector table plus hand-written
// latency, busy-write and reset-abort sequences, all checked through an output scoreboard.
module tb_iir_mac_filter;

    localparam int IO_B = 16;
    localparam int Q    = 32;
    localparam int CA_W = 3;

    logic                   clk;
    logic                   reset_n;
    logic signed [IO_B-1:0] in_data;
    logic [0:0]             in_ch;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [IO_B-1:0] out_data;
    logic [0:0]             out_ch;
    logic                   out_valid;
    logic                   coef_we;
    logic [CA_W-1:0]        coef_addr;
    logic signed [Q-1:0]    coef_wdata;

    iir_mac_filter #(.IO_B(16), .INT_B(7), .FRAC_B(24), .NA(3), .NB(4), .CH(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_ch      (in_ch),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        bit          send;
        logic [0:0]  ch;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic [0:0]  c;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef IIR_SAT_EN
    localparam logic [15:0] SAT_EXP = 16'h7FFF;
`else
    localparam logic [15:0] SAT_EXP = 16'h0000;
`endif

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(bit rst, bit we, int addr, logic [31:0] wd, bit send,
                                int ch, logic [15:0] din, logic [15:0] exp);
        vec_t v;
        v.rst   = rst;
        v.we    = we;
        v.addr  = 3'(addr);
        v.wdata = wd;
        v.send  = send;
        v.ch    = 1'(ch);
        v.din   = din;
        v.exp   = exp;
        return v;
    endfunction

    // Scoreboard: every out_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", {16'd0, out_data}, {16'd0, e.d});
                check("out_ch", {31'd0, out_ch}, {31'd0, e.c});
                check("in_ready_with_valid", {31'd0, in_ready}, 32'd1);
            end
        end
    end

    task automatic do_reset(bit check_vals);
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        coef_we   = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        if (check_vals) begin
            check("rst_in_ready", {31'd0, in_ready}, 32'd1);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_out_data", {16'd0, out_data}, 32'd0);
            check("rst_out_ch", {31'd0, out_ch}, 32'd0);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("wait_idle", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic drain(string name);
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check({name, "_drain"}, sb.size(), 32'd0);
    endtask

    task automatic send(logic [0:0] ch, logic [15:0] d, bit push);
        exp_t e;
        in_valid = 1'b1;
        in_ch    = ch;
        in_data  = d;
        if (push) begin
            e.d = d;
            e.c = ch;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    vec_t vecs[17];

    initial begin
        int lat;
        int seen;
        exp_t e;

        vecs[0]  = mk(1, 0, 0, 32'h0,        1, 0, 16'h4000, 16'h4000);
        vecs[1]  = mk(1, 1, 0, 32'h00800000, 0, 0, 16'h0000, 16'h0000);
        vecs[2]  = mk(0, 1, 3, 32'h00800000, 1, 0, 16'h4000, 16'h2000);
        vecs[3]  = mk(0, 0, 0, 32'h0,        1, 0, 16'h0000, 16'h1000);
        vecs[4]  = mk(0, 0, 0, 32'h0,        1, 0, 16'h0000, 16'h0800);
        vecs[5]  = mk(1, 1, 0, 32'h00800000, 0, 0, 16'h0000, 16'h0000);
        vecs[6]  = mk(0, 1, 3, 32'h00800000, 1, 0, 16'h4000, 16'h2000);
        vecs[7]  = mk(0, 0, 0, 32'h0,        1, 1, 16'h0000, 16'h0000);
        vecs[8]  = mk(0, 0, 0, 32'h0,        1, 0, 16'h0000, 16'h1000);
        vecs[9]  = mk(1, 1, 3, 32'h04000000, 1, 0, 16'h4000, SAT_EXP);
        vecs[10] = mk(1, 1, 7, 32'h0,        1, 1, 16'hC000, 16'hC000);
        vecs[11] = mk(1, 1, 3, 32'h00800000, 1, 0, 16'hFFFF, 16'hFFFF);
        vecs[12] = mk(0, 0, 0, 32'h0,        1, 1, 16'h0001, 16'h0000);
        vecs[13] = mk(1, 1, 4, 32'h00800000, 1, 0, 16'h2000, 16'h2000);
        vecs[14] = mk(0, 0, 0, 32'h0,        1, 0, 16'h1000, 16'h2000);
        vecs[15] = mk(0, 1, 2, 32'h00400000, 1, 0, 16'h0000, 16'h0800);
        vecs[16] = mk(0, 0, 0, 32'h0,        1, 0, 16'h0000, 16'h0800);

        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_ch      = '0;
        in_data    = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;

        // Latency and handshake timing of a single passthrough sample.
        do_reset(1);
        send(1'b0, 16'h4000, 1);
        check("ready_low_after_accept", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 32'd9);
        @(posedge clk); #1;
        check("out_valid_pulse", {31'd0, out_valid}, 32'd0);
        check("out_data_hold", {16'd0, out_data}, 32'h4000);
        drain("latency");

        for (int unsigned i = 0; i < 17; i++) begin
            if (vecs[i].rst) do_reset(0);
            wait_idle();
            coef_we    = vecs[i].we;
            coef_addr  = vecs[i].addr;
            coef_wdata = vecs[i].wdata;
            in_valid   = vecs[i].send;
            in_ch      = vecs[i].ch;
            in_data    = vecs[i].din;
            if (vecs[i].send) begin
                e.d = vecs[i].exp;
                e.c = vecs[i].ch;
                sb.push_back(e);
            end
            @(posedge clk); #1;
            coef_we  = 1'b0;
            in_valid = 1'b0;
            if (vecs[i].send) drain($sformatf("vec%0d", i));
        end

        // A coefficient write while busy must be dropped.
        do_reset(0);
        send(1'b0, 16'h4000, 1);
        @(posedge clk); #1;
        check("busy_ready_low", {31'd0, in_ready}, 32'd0);
        coef_we    = 1'b1;
        coef_addr  = 3'd3;
        coef_wdata = 32'h0;
        @(posedge clk); #1;
        coef_we = 1'b0;
        drain("busy1");
        send(1'b0, 16'h4000, 1);
        drain("busy2");

        // Reset during CALC_B aborts the sample with no output.
        do_reset(0);
        send(1'b0, 16'h7000, 0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_data", {16'd0, out_data}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_valid", seen, 32'd0);
        send(1'b0, 16'h1234, 1);
        drain("abort_next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d mismatches so far, expected completion", n_bad);
        $fatal(1, "watchdog");
    end

endmodule
